sm_fetch: RTL and testbench
===========================

Name: sm_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the combinational instruction ROM.
- Owns the program counter and drives the ROM word address; captures the returned instruction word together with its PC.
- Buffers fetched pairs in a small FIFO and presents them to decode through a valid/ready handshake.
- Accepts redirects from branch/jump resolution, which flush the buffer.

Parameters:
- RESET_PC, 32'h00000000, byte address of the first fetch after reset; bits [1:0] must be 0.
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; 0 freezes all state.
- im_addr  output  32  ROM word address, equal to pc[31:2] zero-extended.
- im_data  input  32  ROM read data, combinational from im_addr in the same cycle.
- redirect_valid  input  1  request to flush the buffer and load a new PC.
- redirect_pc  input  32  new byte address; bits [1:0] are ignored.
- out_valid  output  1  FIFO head holds a valid entry.
- out_ready  input  1  decode accepts the head entry this cycle.
- out_instr  output  32  instruction word at the FIFO head.
- out_pc  output  32  byte PC of the head instruction.
- fifo_count  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - pc = RESET_PC, FIFO empty with count 0 and read/write pointers 0.
  - out_valid=0, out_instr=32'h00000013 (NOP), out_pc=0, fifo_count=0, im_addr=RESET_PC>>2.
- Outputs:
  - out_* are driven combinationally from the head entry of the storage.
  - When the FIFO is empty, out_valid=0, out_instr=32'h00000013 and out_pc=0.
- Pop and push conditions:
  - pop = en & out_valid & out_ready.
  - push = en & !redirect_valid & (count<DEPTH | pop).
  - Pushing into a full FIFO is therefore allowed only when a pop occurs in the same cycle.
- Push action: write {pc, im_data} at the write pointer and set pc <= pc+4.
  - The PC wraps modulo 2^32, so 32'hFFFFFFFC is followed by 0.
  - Pointers wrap modulo DEPTH.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged.
- No push: pc holds and im_addr is stable.
- Redirect (en=1, redirect_valid=1) has the highest priority:
  - pc <= {redirect_pc[31:2],2'b00}.
  - count <= 0 and both pointers <= 0; nothing is pushed that cycle.
  - A pop handshake in the same cycle is considered completed by decode (decode owns that instruction); the FIFO is still fully flushed.
- Redirect latency:
  - Redirect in cycle N → target fetched and pushed at the edge ending cycle N+1.
  - out_valid=1 with out_pc=target during cycle N+2.
- Back-to-back redirects: the last one wins; no stale entry is ever presented.
- en=0: pc, FIFO contents, count and pointers all hold, and redirect is ignored. Outputs keep reflecting the head entry, but no handshake completes.
- Steady state with out_ready=1 held: one instruction per cycle, with consecutive out_pc values incrementing by 4.
- Reset asserted mid-operation: all state returns to reset values immediately, with no wait for a clock edge. The first fetch after deassertion is RESET_PC.
- fifo_count is never greater than DEPTH, and out_valid == (fifo_count != 0).

Test Plan:
- Reset then free-run with out_ready=1 and ROM word i = 32'h1000_0000+i:
  - → out_valid first rises in cycle 2.
  - → out_pc sequence is 0,4,8,…
  - → out_instr sequence is 32'h10000000, 32'h10000001, …
- Hold out_ready=0 for 10 cycles:
  - → fifo_count saturates at 4 and im_addr freezes at 4.
  - → out_pc stays 0.
  - → Releasing out_ready yields out_pc 0,4,8,12,16 with no gaps and no duplicates.
- FIFO full with out_ready=1 for one cycle:
  - → A push and a pop occur together and fifo_count stays 4.
  - → The entry with pc=16 is appended.
- Redirect to 32'h00000043 while 3 entries are buffered:
  - → Next cycle fifo_count=0 and im_addr=16.
  - → One cycle later out_valid=1 with out_pc=32'h40; no old PC ever appears.
- RESET_PC=32'hFFFFFFF8 with out_ready=1:
  - → out_pc sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- Assert rst_n=0 between clock edges mid-stream:
  - → out_valid=0, fifo_count=0 and im_addr=RESET_PC>>2 immediately.
  - → Fetch restarts at RESET_PC after release.
- en=0 for 5 cycles with a concurrent redirect:
  - → No state changes and the redirect is ignored.

Source files
------------

// File: rtl/sm_fetch.sv
// Instruction fetch stage: owns the PC, reads the instruction ROM and
// buffers {pc, instr} pairs in a small FIFO towards decode.
module sm_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  output logic [31:0]              im_addr,
  input  logic [31:0]              im_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;

  logic   push, pop, flush;
  entry_t head;

  // The low two redirect bits carry no information for word fetches.
  logic unused_rpc;
  assign unused_rpc = ^redirect_pc[1:0];

  // Handshake qualifiers; a redirect suppresses the push of that cycle.
  always_comb begin
    pop   = en & out_valid & out_ready;
    flush = en & redirect_valid;
    push  = en & ~redirect_valid & ((count_q < FULL) | pop);
  end

  // Next PC, pointers and occupancy; redirect flushes everything.
  always_comb begin
    pc_d    = pc_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PW'(1);
        pc_d   = pc_q + 32'd4;
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= PC0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage: capture the fetched pair at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wptr_q] <= '{pc: pc_q, instr: im_data};
    end
  end

  // Head entry drives decode; an empty FIFO presents a NOP at pc 0.
  always_comb begin
    head       = mem_q[rptr_q];
    im_addr    = {2'b00, pc_q[31:2]};
    out_valid  = (count_q != '0);
    out_instr  = out_valid ? head.instr : NOP;
    out_pc     = out_valid ? head.pc : 32'h0;
    fifo_count = count_q;
  end

endmodule

// File: tb/tb_sm_fetch.sv
// Self-checking bench for sm_fetch: a queue-based reference model plus
// directed phases and a randomized run with a mid-stream reset.
module tb_sm_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic [31:0] im_addr0, im_data0, out_instr0, out_pc0;
  logic        out_valid0;
  logic [2:0]  fifo_count0;

  logic [31:0] im_addr1, im_data1, out_instr1, out_pc1;
  logic        out_valid1;
  logic [2:0]  fifo_count1;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mpc;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] waddr);
    return 32'h1000_0000 + waddr;
  endfunction

  assign im_data0 = rom(im_addr0);
  assign im_data1 = rom(im_addr1);

  sm_fetch #(.RESET_PC(32'h00000000), .DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .im_addr(im_addr0), .im_data(im_data0),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_instr(out_instr0), .out_pc(out_pc0),
    .fifo_count(fifo_count0)
  );

  sm_fetch #(.RESET_PC(32'hFFFFFFF8), .DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .im_addr(im_addr1), .im_data(im_data1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_instr(out_instr1), .out_pc(out_pc1),
    .fifo_count(fifo_count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] e_pc, e_in;
    e_pc = (q.size() != 0) ? q[0].pc : 32'h0;
    e_in = (q.size() != 0) ? q[0].instr : 32'h00000013;
    chk("out_valid", 32'(out_valid0), 32'(q.size() != 0));
    chk("fifo_count", 32'(fifo_count0), 32'(q.size()));
    chk("out_pc", out_pc0, e_pc);
    chk("out_instr", out_instr0, e_in);
    chk("im_addr", im_addr0, mpc >> 2);
  endtask

  // Model: redirect flushes; otherwise pop, then push if room remains.
  task automatic model_update(input logic e, input logic rv,
                              input logic [31:0] rpc, input logic rdy);
    if (!e) return;
    if (rv) begin
      q.delete();
      mpc = {rpc[31:2], 2'b00};
      return;
    end
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (q.size() < 4) begin
      q.push_back('{pc: mpc, instr: rom(mpc >> 2)});
      mpc = mpc + 32'd4;
    end
  endtask

  task automatic step(input logic e, input logic rv,
                      input logic [31:0] rpc, input logic rdy);
    en             = e;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    check_model();
    @(posedge clk);
    model_update(e, rv, rpc, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    mpc = 32'h0;
    chk("rst_valid", 32'(out_valid0), 32'h0);
    chk("rst_count", 32'(fifo_count0), 32'h0);
    chk("rst_im_addr", im_addr0, 32'h0);
    chk("rst_instr", out_instr0, 32'h00000013);
    chk("rst_valid1", 32'(out_valid1), 32'h0);
    chk("rst_im_addr1", im_addr1, 32'h3FFFFFFE);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] wrap_exp [4];
  int          k;

  initial begin
    rst_n          = 1'b0;
    en             = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    mpc            = 32'h0;
    @(negedge clk);

    // Free run from reset.
    do_reset();
    repeat (10) step(1, 0, 0, 1);

    // Backpressure: saturate, push+pop while full, then drain.
    do_reset();
    repeat (10) step(1, 0, 0, 0);
    chk("sat_count", 32'(fifo_count0), 32'd4);
    chk("sat_im_addr", im_addr0, 32'd4);
    chk("sat_out_pc", out_pc0, 32'h0);
    step(1, 0, 0, 1);
    chk("full_pp_count", 32'(fifo_count0), 32'd4);
    chk("full_pp_head", out_pc0, 32'h4);
    repeat (8) step(1, 0, 0, 1);

    // Redirect with three buffered entries.
    do_reset();
    repeat (3) step(1, 0, 0, 0);
    chk("pre_redir_count", 32'(fifo_count0), 32'd3);
    step(1, 1, 32'h00000043, 0);
    chk("redir_count", 32'(fifo_count0), 32'd0);
    chk("redir_im_addr", im_addr0, 32'd16);
    step(1, 0, 0, 1);
    chk("redir_valid", 32'(out_valid0), 32'd1);
    chk("redir_pc", out_pc0, 32'h40);
    chk("redir_instr", out_instr0, 32'h10000010);
    repeat (4) step(1, 0, 0, 1);

    // Enable low freezes everything, including a pending redirect.
    do_reset();
    repeat (2) step(1, 0, 0, 0);
    repeat (5) step(0, 1, 32'h00000800, 1);
    chk("en0_count", 32'(fifo_count0), 32'd2);
    chk("en0_im_addr", im_addr0, 32'd2);
    chk("en0_out_pc", out_pc0, 32'h0);
    repeat (3) step(1, 0, 0, 1);

    // PC wrap on the second instance.
    wrap_exp[0] = 32'hFFFFFFF8;
    wrap_exp[1] = 32'hFFFFFFFC;
    wrap_exp[2] = 32'h00000000;
    wrap_exp[3] = 32'h00000004;
    do_reset();
    k = 0;
    for (int i = 0; i < 12 && k < 4; i++) begin
      step(1, 0, 0, 1);
      if (out_valid1) begin
        chk("wrap_pc", out_pc1, wrap_exp[k]);
        chk("wrap_instr", out_instr1, rom(wrap_exp[k] >> 2));
        k++;
      end
    end
    chk("wrap_seen", k, 32'd4);

    // Randomized traffic with an asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step($urandom_range(0, 9) != 0,
           $urandom_range(0, 9) == 0,
           $urandom,
           $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
